// File: rtl/rmt_alu_pkg.sv
// Opcode constants and field helpers shared by the RMT action ALU family.
package rmt_alu_pkg;

  localparam int OPCODE_WIDTH = 4;

  localparam logic [3:0] OP_ADD     = 4'b0001;
  localparam logic [3:0] OP_ADD_ALT = 4'b1001;
  localparam logic [3:0] OP_SUB     = 4'b0010;
  localparam logic [3:0] OP_SUB_ALT = 4'b1010;
  localparam logic [3:0] OP_ADDI    = 4'b0011;
  localparam logic [3:0] OP_SUBI    = 4'b0100;
  localparam logic [3:0] OP_AND     = 4'b0101;
  localparam logic [3:0] OP_OR      = 4'b0110;
  localparam logic [3:0] OP_XOR     = 4'b0111;

  // The opcode occupies the top OPCODE_WIDTH bits of the action word.
  function automatic int opcode_lsb(input int action_len);
    return action_len - OPCODE_WIDTH;
  endfunction

endpackage

// File: rtl/alu_1_pipe_if.sv
// Action/operand request and container result bundle for alu_1_pipe.
interface alu_1_pipe_if #(
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48
);
  logic [ACTION_LEN-1:0] action_in;
  logic                  action_valid;
  logic [DATA_WIDTH-1:0] operand_1_in;
  logic [DATA_WIDTH-1:0] operand_2_in;
  logic [DATA_WIDTH-1:0] container_out;
  logic                  container_out_valid;
  logic                  overflow_out;

  modport master (
    output action_in, action_valid, operand_1_in, operand_2_in,
    input  container_out, container_out_valid, overflow_out
  );

  modport slave (
    input  action_in, action_valid, operand_1_in, operand_2_in,
    output container_out, container_out_valid, overflow_out
  );
endinterface

// File: rtl/rmt_valid_delay.sv
// Registered shift line carrying a payload with its valid bit; reset clears every stage.
module rmt_valid_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_valid      = in_valid;
      assign out_data       = in_data;
    end else begin : g_line
      logic             valid_reg [DEPTH];
      logic [WIDTH-1:0] data_reg  [DEPTH];

      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             valid_next;
        logic [WIDTH-1:0] data_next;

        if (gi == 0) begin : g_head
          assign valid_next = in_valid;
          assign data_next  = in_data;
        end else begin : g_body
          assign valid_next = valid_reg[gi-1];
          assign data_next  = data_reg[gi-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            valid_reg[gi] <= 1'b0;
            data_reg[gi]  <= '0;
          end else begin
            valid_reg[gi] <= valid_next;
            data_reg[gi]  <= data_next;
          end
        end
      end

      assign out_valid = valid_reg[DEPTH-1];
      assign out_data  = data_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/alu_1_pipe.sv
// Pipelined first-type RMT action ALU: one sub-action per cycle, result LATENCY cycles later.
module alu_1_pipe
  import rmt_alu_pkg::*;
#(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48,
  parameter int IMM_WIDTH  = 16,
  parameter int LATENCY    = 5,
  parameter int SATURATE   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_1_pipe_if.slave  bus
);

  localparam int OPC_LSB = opcode_lsb(ACTION_LEN);

  logic [3:0]            opcode;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] rhs;
  logic [DATA_WIDTH:0]   wide;
  logic [DATA_WIDTH-1:0] result_next;
  logic                  ovf_next;
  logic                  is_add;
  logic                  is_sub;

  // Bits between the immediate and the opcode carry nothing for this ALU type.
  logic unused_action_bits;
  assign unused_action_bits = ^bus.action_in[OPC_LSB-1:IMM_WIDTH];

  assign opcode  = bus.action_in[OPC_LSB +: OPCODE_WIDTH];
  assign op1     = bus.operand_1_in;
  assign op2     = bus.operand_2_in;
  assign imm_ext = DATA_WIDTH'(bus.action_in[IMM_WIDTH-1:0]);

  always_comb begin
    is_add      = 1'b0;
    is_sub      = 1'b0;
    rhs         = op2;
    result_next = op1;
    ovf_next    = 1'b0;
    wide        = '0;
    case (opcode)
      OP_ADD, OP_ADD_ALT: is_add = 1'b1;
      OP_SUB, OP_SUB_ALT: is_sub = 1'b1;
      OP_ADDI: begin
        is_add = 1'b1;
        rhs    = imm_ext;
      end
      OP_SUBI: begin
        is_sub = 1'b1;
        rhs    = imm_ext;
      end
      OP_AND:  result_next = op1 & op2;
      OP_OR:   result_next = op1 | op2;
      OP_XOR:  result_next = op1 ^ op2;
      default: result_next = op1;
    endcase

    // Bit DATA_WIDTH is the carry-out for add and the borrow for sub.
    if (is_add) begin
      wide = {1'b0, op1} + {1'b0, rhs};
    end else if (is_sub) begin
      wide = {1'b0, op1} - {1'b0, rhs};
    end

    if (is_add || is_sub) begin
      ovf_next = wide[DATA_WIDTH];
      if (SATURATE != 0 && ovf_next) begin
        result_next = is_add ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
      end else begin
        result_next = wide[DATA_WIDTH-1:0];
      end
    end
  end

  logic                  dly_valid;
  logic [DATA_WIDTH:0]   dly_data;

  // The output register is the last stage, so the line itself is one shorter.
  rmt_valid_delay #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (LATENCY - 1)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.action_valid),
    .in_data   ({ovf_next, result_next}),
    .out_valid (dly_valid),
    .out_data  (dly_data)
  );

  logic [DATA_WIDTH-1:0] container_out_reg;
  logic                  container_out_valid_reg;
  logic                  overflow_out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      container_out_reg       <= '0;
      container_out_valid_reg <= 1'b0;
      overflow_out_reg        <= 1'b0;
    end else begin
      container_out_valid_reg <= dly_valid;
      if (dly_valid) begin
        container_out_reg <= dly_data[DATA_WIDTH-1:0];
        overflow_out_reg  <= dly_data[DATA_WIDTH];
      end
    end
  end

  assign bus.container_out       = container_out_reg;
  assign bus.container_out_valid = container_out_valid_reg;
  assign bus.overflow_out        = overflow_out_reg;

endmodule

// File: tb/tb_alu_1_pipe.sv
// Scoreboard bench for alu_1_pipe: wrap, saturate and single-cycle-latency builds driven in lockstep.
module tb_alu_1_pipe;
  import rmt_alu_pkg::*;

  localparam longint unsigned FULL = 64'h1_0000_0000_0000;
  localparam logic [47:0]     ONES = 48'hFFFF_FFFF_FFFF;

  typedef struct {
    logic [47:0] res;
    logic        ovf;
    int          due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q2[$];
  logic [47:0] last_res [3];
  logic        last_ovf [3];
  int          lat_k    [3] = '{5, 5, 1};
  bit          sat_k    [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_1_pipe_if #(.ACTION_LEN(25), .DATA_WIDTH(48)) if0 ();
  alu_1_pipe_if #(.ACTION_LEN(25), .DATA_WIDTH(48)) if1 ();
  alu_1_pipe_if #(.ACTION_LEN(25), .DATA_WIDTH(48)) if2 ();

  alu_1_pipe #(.LATENCY(5), .SATURATE(0)) dut_wrap (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  alu_1_pipe #(.LATENCY(5), .SATURATE(1)) dut_sat  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  alu_1_pipe #(.LATENCY(1), .SATURATE(0)) dut_lat1 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  // Reference: unsigned arithmetic on 64-bit integers, then wrap or clamp at 2**48.
  function automatic void model(input logic [3:0] op, input logic [15:0] imm,
                                input logic [47:0] a, input logic [47:0] b, input bit sat,
                                output logic [47:0] res, output logic ovf);
    longint unsigned x = 64'(a);
    longint unsigned y = 64'(b);
    longint unsigned r;
    if (op == 4'd3 || op == 4'd4) y = 64'(imm);
    ovf = 1'b0;
    case (op)
      4'd1, 4'd9, 4'd3: begin
        r   = x + y;
        ovf = (r >= FULL);
        if (ovf) r = sat ? FULL - 1 : r - FULL;
      end
      4'd2, 4'd10, 4'd4: begin
        ovf = (x < y);
        if (ovf) r = sat ? 64'd0 : x + FULL - y;
        else     r = x - y;
      end
      4'd5:    r = x & y;
      4'd6:    r = x | y;
      4'd7:    r = x ^ y;
      default: r = x;
    endcase
    res = r[47:0];
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int k, output exp_t e);
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic qpush(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drive(input logic v, input logic [24:0] act, input logic [47:0] a, input logic [47:0] b);
    if0.action_valid = v; if0.action_in = act; if0.operand_1_in = a; if0.operand_2_in = b;
    if1.action_valid = v; if1.action_in = act; if1.operand_1_in = a; if1.operand_2_in = b;
    if2.action_valid = v; if2.action_in = act; if2.operand_1_in = a; if2.operand_2_in = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] imm, input logic [47:0] a, input logic [47:0] b);
    logic [24:0] act;
    exp_t        e;
    act = {op, 5'($urandom), imm};
    drive(1'b1, act, a, b);
    for (int k = 0; k < 3; k++) begin
      model(op, imm, a, b, sat_k[k], e.res, e.ovf);
      e.due = cyc + lat_k[k];
      qpush(k, e);
    end
    step();
  endtask

  task automatic bubble();
    drive(1'b0, 25'($urandom), {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)});
    step();
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, '0);
    rst_n = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    for (int k = 0; k < 3; k++) begin
      last_res[k] = '0;
      last_ovf[k] = 1'b0;
    end
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [47:0] pick();
    case ($urandom_range(0, 3))
      0:       return 48'd0;
      1:       return ONES;
      2:       return 48'($urandom_range(0, 255));
      default: return {16'($urandom), 32'($urandom)};
    endcase
  endfunction

  task automatic check_port(input int k, input logic v, input logic [47:0] d, input logic o);
    exp_t e;
    while (qsize(k) > 0 && qfront(k).due < cyc) begin
      qpop(k, e);
      checks++;
      errors++;
      $display("FAIL missing_pulse dut%0d: no result at cycle %0d, required 0x%012h ovf=%0b", k, e.due, e.res, e.ovf);
    end
    checks++;
    if (v) begin
      if (qsize(k) == 0) begin
        errors++;
        $display("FAIL unexpected_pulse dut%0d cyc=%0d: got 0x%012h ovf=%0b, required no pulse", k, cyc, d, o);
      end else begin
        qpop(k, e);
        last_res[k] = e.res;
        last_ovf[k] = e.ovf;
        if (d !== e.res || o !== e.ovf || cyc != e.due) begin
          errors++;
          $display("FAIL result dut%0d: got 0x%012h ovf=%0b at cyc %0d, required 0x%012h ovf=%0b at cyc %0d",
                   k, d, o, cyc, e.res, e.ovf, e.due);
        end else begin
          $display("dut%0d cyc=%0d result 0x%012h ovf=%0b ok", k, cyc, d, o);
        end
      end
    end else if (d !== last_res[k] || o !== last_ovf[k]) begin
      errors++;
      $display("FAIL hold dut%0d cyc=%0d: got 0x%012h ovf=%0b, required 0x%012h ovf=%0b",
               k, cyc, d, o, last_res[k], last_ovf[k]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_port(0, if0.container_out_valid, if0.container_out, if0.overflow_out);
      check_port(1, if1.container_out_valid, if1.container_out, if1.overflow_out);
      check_port(2, if2.container_out_valid, if2.container_out, if2.overflow_out);
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      last_res[k] = '0;
      last_ovf[k] = 1'b0;
    end
    drive(1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(OP_ADD, 16'h0, 48'h10, 48'h22);
    repeat (7) bubble();

    issue(OP_ADD,  16'h0,    48'd1,    48'd2);
    issue(OP_SUB,  16'h0,    48'd9,    48'd4);
    issue(OP_ADDI, 16'h0100, 48'd7,    pick());
    issue(OP_XOR,  16'h0,    48'hF0,   48'hFF);
    repeat (6) bubble();

    issue(OP_ADD,     16'h0,    ONES,     48'd1);
    issue(OP_SUB,     16'h0,    48'd3,    48'd5);
    issue(OP_ADD_ALT, 16'h0,    ONES,     ONES);
    issue(OP_SUB_ALT, 16'h0,    48'd0,    48'd1);
    issue(OP_SUBI,    16'h0010, 48'd4,    pick());
    issue(OP_ADDI,    16'hFFFF, ONES,     pick());
    issue(4'b0000,    16'h0,    48'hABC,  pick());
    issue(4'b1111,    16'h0,    48'hABC,  pick());
    issue(OP_AND,     16'h0,    48'hF0F0, 48'hFF00);
    issue(OP_OR,      16'h0,    48'hF0F0, 48'h0F0F);
    repeat (6) bubble();

    issue(OP_ADD, 16'h0, 48'd5, 48'd6);
    bubble();
    issue(OP_SUB, 16'h0, 48'd20, 48'd1);
    do_reset();
    issue(OP_ADD, 16'h0, 48'd100, 48'd23);
    repeat (6) bubble();

    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      if ($urandom_range(0, 3) == 0) bubble();
      else issue(4'($urandom_range(0, 15)), 16'($urandom), pick(), pick());
    end
    repeat (10) bubble();

    for (int k = 0; k < 3; k++) begin
      checks++;
      if (qsize(k) != 0) begin
        errors++;
        $display("FAIL drain dut%0d: got %0d results outstanding, required 0", k, qsize(k));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_1_pipe.md
Name: alu_1_pipe

Overview:
- Parametrised, fully pipelined successor to the first-type (no load/store) RMT action ALU.
- Takes one sub-action and two operands per cycle and produces one PHV container result.
- Result appears a fixed LATENCY cycles later and can be issued back-to-back, with no idle cycles between actions.
- Adds immediate operands, bitwise ops, optional unsigned saturation and an overflow flag; sits between sub_action decode and PHV re-assembly in each stage.

Parameters:
- STAGE_ID, 0, stage index; informational only, no functional effect.
- ACTION_LEN, 25, width of action_in.
- DATA_WIDTH, 48, operand/result width; legal range 8..64.
- IMM_WIDTH, 16, immediate field width; must be < ACTION_LEN-4.
- LATENCY, 5, cycles from action_valid sample to container_out_valid; legal range >=1.
- SATURATE, 0, 1 = unsigned clamp on add/sub overflow, 0 = modulo wrap.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- action_in  input  ACTION_LEN  opcode = action_in[ACTION_LEN-1 -: 4]; imm = action_in[IMM_WIDTH-1:0].
- action_valid  input  1  action/operands valid this cycle.
- operand_1_in  input  DATA_WIDTH  first operand (header field).
- operand_2_in  input  DATA_WIDTH  second operand (header field).
- container_out  output  DATA_WIDTH  result; holds last value between results.
- container_out_valid  output  1  one-cycle pulse per result.
- overflow_out  output  1  qualified by container_out_valid; add carry-out or sub borrow occurred.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. On reset, all pipeline valid bits clear and container_out=0, container_out_valid=0, overflow_out=0.
- Stage 1 (cycle of sampling): when action_valid=1, decode the opcode and compute the result at DATA_WIDTH+1 bits. Operands are unsigned.
- Opcode map:
  - 0001/1001: op1+op2
  - 0010/1010: op1-op2
  - 0011: op1+imm
  - 0100: op1-imm
  - 0101: op1&op2
  - 0110: op1|op2
  - 0111: op1^op2
  - any other code: op1 pass-through (empty action)
- Immediate handling: imm is zero-extended to DATA_WIDTH.
- Overflow: overflow = bit DATA_WIDTH of the add result, or the borrow of the sub. Overflow is 0 for logical and pass-through ops.
- SATURATE=1: add overflow -> result all ones; sub borrow -> result 0. overflow_out is still 1.
- SATURATE=0: result = low DATA_WIDTH bits (wrap).
- Pipeline: result, overflow and valid enter a delay line. An action sampled at edge N gives container_out_valid=1 during cycle N+LATENCY, with container_out/overflow_out updated at that same edge.
- container_out and overflow_out change only when a valid result leaves the pipe; otherwise they hold.
- Throughput: 1 action/cycle. No backpressure exists; downstream must accept every pulse.
- action_valid=0 cycles inject bubbles and produce no pulse. Operands are don't-care while action_valid=0.
- LATENCY=1: the result is registered directly, with no delay stages.
- Reset mid-operation: all in-flight actions are dropped. No output pulse occurs for them after reset deasserts.
- There is no FSM; the design is a pure valid-qualified shift pipeline. Its latency is independent of the opcode.

Decomposition:
- Shared package rmt_alu_pkg: 4-bit opcode constants (OP_ADD, OP_ADD_ALT, OP_SUB, OP_SUB_ALT, OP_ADDI, OP_SUBI, OP_AND, OP_OR, OP_XOR) and the opcode field position helper. These are reused by alu_2/alu_3 successors.
- One sub-module, rmt_valid_delay: parametrised WIDTH/DEPTH registered shift line with valid, async active-low reset and valid-bit clearing. It carries {overflow, result} for LATENCY-1 stages.

Test Plan:
- Reset then single add: op1=0x10, op2=0x22, opcode 0001, pulse at cycle 0 -> cycle 5 container_out=0x32, valid=1 for exactly one cycle, overflow_out=0; the value holds afterwards.
- Back-to-back: 4 consecutive actions (add 1+2, sub 9-4, addi 7+imm 0x0100, xor 0xF0^0xFF) -> valid high cycles 5..8 with 0x3, 0x5, 0x107, 0x0F in order.
- Overflow: add 0xFFFF_FFFF_FFFF+1 -> SATURATE=0: 0x0, overflow=1; SATURATE=1: 0xFFFF_FFFF_FFFF, overflow=1. Sub 3-5 -> wrap 0xFFFF_FFFF_FFFE or clamp 0x0, overflow=1 in both cases.
- Default opcode 0000 and 1111 with op1=0xABC -> container_out=0xABC, overflow=0.
- Bubbles plus reset mid-flight: issue actions at cycles 0 and 2, assert rst_n=0 at cycle 3 for 1 cycle -> no valid pulses; container_out=0 after reset; the next action completes with a normal 5-cycle latency.
- LATENCY=1 build: add 5+6 at cycle 0 -> cycle 1 container_out=0xB, valid=1.
